// File: rtl/sm83_adr_seq.sv
// Address-path sequencer: turns one decoded address command into LOAD/STEP beats
// of address-latch and incrementer strobes, paced by the machine-cycle tick.
module sm83_adr_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       m_tick,
    input  logic       flush,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_len,
    output logic       ctl_al_we,
    output logic       ctl_al_hi_ff,
    output logic       ctl_inc_oe,
    output logic       ctl_inc_cy,
    output logic       ctl_inc_dec,
    output logic       wb_we,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_FETCH = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_HIGH  = 3'd4;
    localparam logic [2:0] OP_INCRR = 3'd5;
    localparam logic [2:0] OP_DECRR = 3'd6;
    localparam logic [2:0] OP_HOLD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     state_reg;
    logic [2:0] op_reg;
    logic [1:0] rem_reg;
    logic       nop_done_reg;

    logic       abort;
    logic       accept;
    logic       load_beat;
    logic       step_beat;
    logic       step_inc;
    logic       step_dec;
    logic       step_move;
    logic [1:0] rem_init;

    // reset and flush both kill the current beat and block a new accept
    assign abort     = reset || flush;
    assign cmd_ready = (state_reg == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;

    assign load_beat = m_tick && !abort && (state_reg == ST_LOAD);
    assign step_beat = m_tick && !abort && (state_reg == ST_STEP);

    assign step_inc  = (op_reg == OP_FETCH) || (op_reg == OP_POP) || (op_reg == OP_INCRR);
    assign step_dec  = (op_reg == OP_PUSH) || (op_reg == OP_DECRR);
    assign step_move = step_inc || step_dec;

    // HOLD steps fall through step_move=0, so the latch simply keeps its value
    always_comb begin
        ctl_al_we    = 1'b0;
        ctl_al_hi_ff = 1'b0;
        ctl_inc_oe   = 1'b0;
        ctl_inc_cy   = 1'b0;
        ctl_inc_dec  = 1'b0;
        wb_we        = 1'b0;
        if (load_beat) begin
            ctl_al_we    = 1'b1;
            ctl_al_hi_ff = (op_reg == OP_HIGH);
        end else if (step_beat && step_move) begin
            ctl_al_we   = 1'b1;
            ctl_inc_oe  = 1'b1;
            ctl_inc_cy  = 1'b1;
            ctl_inc_dec = step_dec;
            wb_we       = 1'b1;
        end
    end

    always_comb begin
        rem_init = 2'd0;
        case (cmd_op)
            OP_FETCH, OP_PUSH, OP_POP, OP_HOLD: rem_init = cmd_len;
            OP_INCRR, OP_DECRR:                 rem_init = 2'd1;
            default:                            rem_init = 2'd0;
        endcase
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE) || nop_done_reg;

    always_ff @(posedge clk) begin
        if (abort) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_NOP;
            rem_reg      <= 2'd0;
            nop_done_reg <= 1'b0;
        end else begin
            nop_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        // NOP completes without leaving IDLE
                        if (cmd_op == OP_NOP) begin
                            nop_done_reg <= 1'b1;
                        end else begin
                            op_reg    <= cmd_op;
                            rem_reg   <= rem_init;
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (m_tick) begin
                        state_reg <= (rem_reg != 2'd0) ? ST_STEP : ST_DONE;
                    end
                end
                ST_STEP: begin
                    if (m_tick) begin
                        rem_reg <= rem_reg - 2'd1;
                        if (rem_reg == 2'd1) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
